// File: rtl/snr_meas_pkg.sv
// snr_meas_pkg: shared constants for the SNR measurement controller --
// register word offsets, CTRL/STATUS bit positions, FSM state codes,
// ID register prefix and register reset values.
package snr_meas_pkg;

   // Word offsets on PADDR[11:2] (byte offset >> 2)
   localparam logic [9:0] OFF_CTRL   = 10'd0;
   localparam logic [9:0] OFF_WINDOW = 10'd1;
   localparam logic [9:0] OFF_THRESH = 10'd2;
   localparam logic [9:0] OFF_STATUS = 10'd3;
   localparam logic [9:0] OFF_RESULT = 10'd4;
   localparam logic [9:0] OFF_COUNT  = 10'd5;
   localparam logic [9:0] OFF_PEAK   = 10'd6;
   localparam logic [9:0] OFF_ID     = 10'd7;

   // CTRL bit positions
   localparam int CTRL_START  = 3;
   localparam int CTRL_IRQ_EN = 2;
   localparam int CTRL_CONT   = 1;
   localparam int CTRL_EN     = 0;

   // STATUS bit positions (BUSY is live, the rest are sticky)
   localparam int ST_BUSY = 4;
   localparam int ST_OVR  = 3;
   localparam int ST_TMO  = 2;
   localparam int ST_LOW  = 1;
   localparam int ST_DONE = 0;

   // Measurement sequencer states
   typedef logic [1:0] fsm_state_t;
   localparam fsm_state_t S_IDLE = 2'd0;
   localparam fsm_state_t S_ARM  = 2'd1;
   localparam fsm_state_t S_WAIT = 2'd2;
   localparam fsm_state_t S_GAP  = 2'd3;

   localparam logic [27:0] ID_PREFIX  = 28'h5C0_0001;
   localparam logic [15:0] WINDOW_RST = 16'd1;

   // A zero-length window is meaningless to the estimator; clamp it to one sample
   function automatic logic [15:0] window_sanitize(input logic [15:0] w);
      return (w == 16'd0) ? 16'd1 : w;
   endfunction

endpackage

// File: rtl/snr_meas_fsm.sv
// snr_meas_fsm: measurement sequencer. Issues one-cycle est_start pulses,
// watches for est_done with a timeout, spaces continuous-mode measurements
// by GAP_CYC idle cycles and reports done/timeout/overrun events to the top.
module snr_meas_fsm
   import snr_meas_pkg::*;
#(
   parameter int TIMEOUT_CYC = 65535,
   parameter int GAP_CYC     = 16
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        start_req,   // START written together with EN=1
   input  logic        en,          // EN including a CTRL write in flight
   input  logic        cont,
   input  logic [15:0] window,
   input  logic        est_done,
   output fsm_state_t  state,
   output logic        est_start,
   output logic [15:0] est_len,
   output logic        done_evt,
   output logic        tmo_evt,
   output logic        ovr_evt
);

   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
   localparam logic [31:0] GAP_LAST = 32'(GAP_CYC - 1);

   fsm_state_t  state_reg, state_next;
   logic [31:0] tmo_cnt_reg, tmo_cnt_next;
   logic [31:0] gap_cnt_reg, gap_cnt_next;
   logic [15:0] est_len_reg;
   logic        wait_expired;

   assign wait_expired = (tmo_cnt_reg == TMO_LAST);
   assign done_evt     = (state_reg == S_WAIT) & est_done;
   assign tmo_evt      = (state_reg == S_WAIT) & ~est_done & wait_expired;
   assign ovr_evt      = (state_reg != S_WAIT) & est_done;
   assign est_start    = (state_reg == S_ARM);
   assign est_len      = est_len_reg;
   assign state        = state_reg;

   // Next-state and counter logic; dropping EN aborts from any busy state
   always_comb begin
      state_next   = state_reg;
      tmo_cnt_next = tmo_cnt_reg;
      gap_cnt_next = gap_cnt_reg;
      case (state_reg)
         S_IDLE: if (start_req) state_next = S_ARM;
         S_ARM: begin
            tmo_cnt_next = '0;
            state_next   = S_WAIT;
         end
         S_WAIT: begin
            if (est_done) begin
               if (!cont)             state_next = S_IDLE;
               else if (GAP_CYC == 0) state_next = S_ARM;
               else begin
                  state_next   = S_GAP;
                  gap_cnt_next = '0;
               end
            end else if (wait_expired) begin
               state_next = S_IDLE;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + 32'd1;
            end
         end
         S_GAP: begin
            if (gap_cnt_reg == GAP_LAST) state_next = cont ? S_ARM : S_IDLE;
            else                          gap_cnt_next = gap_cnt_reg + 32'd1;
         end
         default: state_next = S_IDLE;
      endcase
      if ((state_reg != S_IDLE) && !en) state_next = S_IDLE;
   end

   // State and counter registers; est_len is captured only when entering ARM
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_reg   <= S_IDLE;
         tmo_cnt_reg <= '0;
         gap_cnt_reg <= '0;
         est_len_reg <= WINDOW_RST;
      end else begin
         state_reg   <= state_next;
         tmo_cnt_reg <= tmo_cnt_next;
         gap_cnt_reg <= gap_cnt_next;
         if (state_next == S_ARM) est_len_reg <= window;
      end
   end

endmodule

// File: rtl/snr_meas_ctrl.sv
// snr_meas_ctrl: APB3 register file, sticky status and interrupt for the
// SNR estimator sequencer (snr_meas_fsm).
// Optional build macro SNR_PEAK_EN adds the PEAK register at 0x18; without
// it 0x18 reads 0 and writes are ignored.
module snr_meas_ctrl
   import snr_meas_pkg::*;
#(
   parameter int TIMEOUT_CYC = 65535,
   parameter int GAP_CYC     = 16
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [11:2] PADDR,
   input  logic [31:0] PWDATA,
   input  logic [3:0]  ECOREVNUM,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic        est_start,
   output logic [15:0] est_len,
   input  logic        est_done,
   input  logic [16:0] est_snr,
   output logic        irq
);

   logic [2:0]  ctrl_reg;      // {IRQ_EN, CONT, EN}
   logic [15:0] window_reg;
   logic [16:0] thresh_reg;
   logic [3:0]  status_reg, status_next;   // {OVR, TMO, LOW, DONE}
   logic [16:0] result_reg;
   logic [15:0] count_reg;
   logic [31:0] prdata_reg, rdata_mux;
   logic [31:0] peak_rd;
   logic [3:0]  hw_set, w1c_mask;
   logic        wr_access, rd_setup, addr_valid, wr_en;
   logic        wr_ctrl, wr_window, wr_thresh, wr_status;
   logic        en_eff, start_req, busy;
   logic        done_evt, tmo_evt, ovr_evt;
   fsm_state_t  state;
   logic        unused_pwdata;

   assign wr_access  = PSEL & PENABLE & PWRITE;
   assign rd_setup   = PSEL & ~PENABLE & ~PWRITE;
   assign addr_valid = (PADDR <= OFF_ID);
   assign wr_en      = wr_access & addr_valid;
   assign wr_ctrl    = wr_en & (PADDR == OFF_CTRL);
   assign wr_window  = wr_en & (PADDR == OFF_WINDOW);
   assign wr_thresh  = wr_en & (PADDR == OFF_THRESH);
   assign wr_status  = wr_en & (PADDR == OFF_STATUS);

   assign PREADY  = 1'b1;
   assign PSLVERR = PSEL & PENABLE & ~addr_valid;
   assign PRDATA  = prdata_reg;
   assign unused_pwdata = &{1'b0, PWDATA[31:17]};

   // A CTRL write clearing EN must stop the sequencer at that same edge
   assign en_eff    = wr_ctrl ? PWDATA[CTRL_EN] : ctrl_reg[CTRL_EN];
   assign start_req = wr_ctrl & PWDATA[CTRL_START] & PWDATA[CTRL_EN];
   assign busy      = (state != S_IDLE);

   snr_meas_fsm #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .GAP_CYC     (GAP_CYC)
   ) u_fsm (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .start_req (start_req),
      .en        (en_eff),
      .cont      (ctrl_reg[CTRL_CONT]),
      .window    (window_reg),
      .est_done  (est_done),
      .state     (state),
      .est_start (est_start),
      .est_len   (est_len),
      .done_evt  (done_evt),
      .tmo_evt   (tmo_evt),
      .ovr_evt   (ovr_evt)
   );

   // Sticky status: W1C clears first, hardware sets override in the same cycle
   always_comb begin
      hw_set      = {ovr_evt, tmo_evt, done_evt & (est_snr < thresh_reg), done_evt};
      w1c_mask    = wr_status ? PWDATA[3:0] : 4'd0;
      status_next = (status_reg & ~w1c_mask) | hw_set;
   end

   assign irq = ctrl_reg[CTRL_IRQ_EN] &
                (status_reg[ST_DONE] | status_reg[ST_LOW] | status_reg[ST_TMO]);

   // Programmable registers, status, latched result and completion count
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         ctrl_reg   <= '0;
         window_reg <= WINDOW_RST;
         thresh_reg <= '0;
         status_reg <= '0;
         result_reg <= '0;
         count_reg  <= '0;
      end else begin
         status_reg <= status_next;
         if (wr_ctrl)   ctrl_reg   <= PWDATA[2:0];
         if (wr_window) window_reg <= window_sanitize(PWDATA[15:0]);
         if (wr_thresh) thresh_reg <= PWDATA[16:0];
         if (done_evt) begin
            result_reg <= est_snr;
            count_reg  <= count_reg + 16'd1;
         end
      end
   end

`ifdef SNR_PEAK_EN
   logic [16:0] peak_reg;
   logic        wr_peak;

   assign wr_peak = wr_en & (PADDR == OFF_PEAK);
   assign peak_rd = {15'd0, peak_reg};

   // Running maximum of accepted results; any write to PEAK restarts it
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)                             peak_reg <= '0;
      else if (wr_peak)                         peak_reg <= '0;
      else if (done_evt && est_snr > peak_reg) peak_reg <= est_snr;
   end
`else
   assign peak_rd = '0;
`endif

   // Read mux; unmapped offsets return zero
   always_comb begin
      rdata_mux = '0;
      case (PADDR)
         OFF_CTRL:   rdata_mux = {29'd0, ctrl_reg};
         OFF_WINDOW: rdata_mux = {16'd0, window_reg};
         OFF_THRESH: rdata_mux = {15'd0, thresh_reg};
         OFF_STATUS: rdata_mux = {27'd0, busy, status_reg};
         OFF_RESULT: rdata_mux = {15'd0, result_reg};
         OFF_COUNT:  rdata_mux = {16'd0, count_reg};
         OFF_PEAK:   rdata_mux = peak_rd;
         OFF_ID:     rdata_mux = {ID_PREFIX, ECOREVNUM};
         default:    rdata_mux = '0;
      endcase
   end

   // Read data is captured in the setup phase and held until the next read
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)      prdata_reg <= '0;
      else if (rd_setup) prdata_reg <= rdata_mux;
   end

endmodule

// File: tb/tb_snr_meas_ctrl.sv
// tb_snr_meas_ctrl: self-checking bench for snr_meas_ctrl. Plays the role of
// the APB master and the SNR estimator, and keeps an abstract model of the
// register contents (sticky flags, result, count, peak) updated per transaction.
module tb_snr_meas_ctrl;

   localparam int TMO = 100;
   localparam int GAP = 16;

   localparam logic [31:0] A_CTRL   = 32'h00;
   localparam logic [31:0] A_WINDOW = 32'h04;
   localparam logic [31:0] A_THRESH = 32'h08;
   localparam logic [31:0] A_STATUS = 32'h0C;
   localparam logic [31:0] A_RESULT = 32'h10;
   localparam logic [31:0] A_COUNT  = 32'h14;
   localparam logic [31:0] A_PEAK   = 32'h18;
   localparam logic [31:0] A_ID     = 32'h1C;
   localparam logic [31:0] A_BAD    = 32'h20;

   logic        PCLK, PRESETn, PSEL, PENABLE, PWRITE;
   logic [11:2] PADDR;
   logic [31:0] PWDATA, PRDATA;
   logic [3:0]  ECOREVNUM;
   logic        PREADY, PSLVERR, est_start, est_done, irq;
   logic [15:0] est_len;
   logic [16:0] est_snr;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model of the programmer-visible state
   int          m_count;
   logic [16:0] m_result, m_thresh, m_peak;
   logic [15:0] m_window;
   logic        m_done, m_low, m_tmo, m_ovr, m_irq_en;

   logic [31:0] rnd_d, rd_data;
   logic [3:0]  rnd_mask;
   logic        rnd_ie, rd_err, seen;
   int          n;

   snr_meas_ctrl #(.TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .ECOREVNUM(ECOREVNUM),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .est_start(est_start), .est_len(est_len), .est_done(est_done),
      .est_snr(est_snr), .irq(irq)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
      logic err;
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr[11:2]; PWDATA = data;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      #1 err = PSLVERR;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      check_val("wr_pslverr", {31'd0, err}, {31'd0, addr >= A_BAD});
   endtask

   task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr[11:2];
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      #1 err = PSLVERR; data = PRDATA;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic rd_chk(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      logic [31:0] d;
      logic        e;
      apb_read(addr, d, e);
      check_val(tag, d, exp);
      if (addr >= A_BAD) check_val({tag, "_err"}, {31'd0, e}, 32'd1);
   endtask

   function automatic logic [31:0] exp_status(input logic busy);
      return {27'd0, busy, m_ovr, m_tmo, m_low, m_done};
   endfunction

   function automatic logic [31:0] exp_peak();
`ifdef SNR_PEAK_EN
      return {15'd0, m_peak};
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic [31:0] exp_irq();
      return {31'd0, m_irq_en & (m_done | m_low | m_tmo)};
   endfunction

   task automatic model_done(input logic [16:0] snr);
      m_result = snr;
      m_count  = (m_count + 1) % 65536;
      m_done   = 1'b1;
      if (snr < m_thresh) m_low = 1'b1;
      if (snr > m_peak)   m_peak = snr;
   endtask

   task automatic model_w1c(input logic [3:0] mask);
      if (mask[0]) m_done = 1'b0;
      if (mask[1]) m_low  = 1'b0;
      if (mask[2]) m_tmo  = 1'b0;
      if (mask[3]) m_ovr  = 1'b0;
   endtask

   // Called in the ARM cycle: checks the start pulse, answers after lat WAIT cycles
   task automatic pulse_done(input int lat, input logic [16:0] snr);
      check_val("est_start_hi", {31'd0, est_start}, 32'd1);
      check_val("est_len", {16'd0, est_len}, {16'd0, m_window});
      @(posedge PCLK); #1;
      check_val("est_start_1cyc", {31'd0, est_start}, 32'd0);
      repeat (lat - 1) begin @(posedge PCLK); #1; end
      est_done = 1'b1; est_snr = snr;
      @(posedge PCLK); #1;
      est_done = 1'b0;
      model_done(snr);
   endtask

   // Counts edges until est_start is seen, bounded
   task automatic wait_start(input int max_cyc, output int cnt);
      logic found;
      found = 1'b0;
      cnt = 0;
      while (!found && cnt < max_cyc) begin
         @(posedge PCLK); #1;
         cnt++;
         if (est_start) found = 1'b1;
      end
      check_val("start_seen", {31'd0, found}, 32'd1);
   endtask

   task automatic single_measure(input int lat, input logic [16:0] snr);
      apb_write(A_CTRL, {28'd0, 1'b1, m_irq_en, 2'b01});
      pulse_done(lat, snr);
   endtask

   initial begin
      PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; ECOREVNUM = 4'd3; est_done = 1'b0; est_snr = '0;
      m_count = 0; m_result = '0; m_thresh = '0; m_peak = '0; m_window = 16'd1;
      m_done = 1'b0; m_low = 1'b0; m_tmo = 1'b0; m_ovr = 1'b0; m_irq_en = 1'b0;

      // Reset state
      repeat (3) @(posedge PCLK);
      #1;
      check_val("rst_prdata", PRDATA, 32'd0);
      check_val("rst_est_len", {16'd0, est_len}, 32'd1);
      check_val("rst_irq", {31'd0, irq}, 32'd0);
      check_val("rst_est_start", {31'd0, est_start}, 32'd0);
      check_val("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
      check_val("pready", {31'd0, PREADY}, 32'd1);
      PRESETn = 1'b1;
      rd_chk(A_CTRL, 32'd0, "rst_ctrl");
      rd_chk(A_WINDOW, 32'd1, "rst_window");
      rd_chk(A_THRESH, 32'd0, "rst_thresh");
      rd_chk(A_STATUS, 32'd0, "rst_status");
      rd_chk(A_RESULT, 32'd0, "rst_result");
      rd_chk(A_COUNT, 32'd0, "rst_count");
      rd_chk(A_PEAK, 32'd0, "rst_peak");

      // 1: single-shot measurement
      apb_write(A_WINDOW, 32'd256); m_window = 16'd256;
      apb_write(A_CTRL, 32'h5); m_irq_en = 1'b1;
      apb_write(A_CTRL, 32'hD);
      pulse_done(40, 17'h00800);
      check_val("t1_irq", {31'd0, irq}, 32'd1);
      rd_chk(A_RESULT, 32'h800, "t1_result");
      rd_chk(A_COUNT, 32'd1, "t1_count");
      rd_chk(A_STATUS, exp_status(1'b0), "t1_status");

      // 2: threshold compare and W1C/set collision
      apb_write(A_THRESH, 32'h01000); m_thresh = 17'h01000;
      apb_write(A_STATUS, 32'h1F); model_w1c(4'hF);
      single_measure(5, 17'h00FFF);
      rd_chk(A_STATUS, exp_status(1'b0), "t2_low_set");
      apb_write(A_STATUS, 32'h2); model_w1c(4'h2);
      single_measure(7, 17'h01000);
      rd_chk(A_STATUS, exp_status(1'b0), "t2_low_equal");
      apb_write(A_CTRL, 32'hD);
      check_val("t2_est_start", {31'd0, est_start}, 32'd1);
      @(posedge PCLK); #1;
      fork
         apb_write(A_STATUS, 32'h2);
         begin
            @(posedge PCLK); #1;
            @(posedge PCLK); #1;
            est_done = 1'b1; est_snr = 17'h00100;
            @(posedge PCLK); #1;
            est_done = 1'b0;
         end
      join
      model_w1c(4'h2);
      model_done(17'h00100);
      rd_chk(A_STATUS, exp_status(1'b0), "t2_set_wins");

      // 3: continuous mode spacing, then EN abort and late est_done
      apb_write(A_STATUS, 32'h1F); model_w1c(4'hF);
      apb_write(A_CTRL, 32'hF);
      for (int k = 0; k < 3; k++) begin
         pulse_done(int'($urandom_range(1, 60)), 17'($urandom));
         wait_start(64, n);
         check_val("t3_gap", n, GAP);
      end
      rd_chk(A_COUNT, m_count, "t3_count");
      apb_write(A_CTRL, 32'h4);
      est_done = 1'b1; est_snr = 17'h1ABCD;
      @(posedge PCLK); #1;
      est_done = 1'b0;
      m_ovr = 1'b1;
      rd_chk(A_STATUS, exp_status(1'b0), "t3_ovr");
      rd_chk(A_RESULT, {15'd0, m_result}, "t3_result_kept");
      rd_chk(A_COUNT, m_count, "t3_count_kept");

      // 4: timeout
      apb_write(A_STATUS, 32'h1F); model_w1c(4'hF);
      apb_write(A_CTRL, 32'hD);
      check_val("t4_est_start", {31'd0, est_start}, 32'd1);
      check_val("t4_irq_before", {31'd0, irq}, 32'd0);
      n = 0; seen = 1'b0;
      while (!seen && n < 200) begin
         @(posedge PCLK); #1;
         n++;
         if (irq) seen = 1'b1;
      end
      check_val("t4_tmo_cycle", n, TMO + 1);
      m_tmo = 1'b1;
      rd_chk(A_STATUS, exp_status(1'b0), "t4_status");
      rd_chk(A_COUNT, m_count, "t4_count");

      // 5: ID, unmapped access, WINDOW clamp, read-only write
      rd_chk(A_ID, 32'h5C000013, "t5_id");
      rd_chk(A_BAD, 32'd0, "t5_bad_rd");
      apb_write(A_BAD, 32'hFFFF_FFFF);
      apb_write(A_WINDOW, 32'd0); m_window = 16'd1;
      rd_chk(A_WINDOW, 32'd1, "t5_window0");
      apb_write(A_RESULT, 32'h1234);
      rd_chk(A_RESULT, {15'd0, m_result}, "t5_result_ro");

      // 6: peak tracking
      apb_write(A_PEAK, 32'hFFFF); m_peak = '0;
      single_measure(3, 17'h00100);
      single_measure(3, 17'h00300);
      single_measure(3, 17'h00200);
      rd_chk(A_PEAK, exp_peak(), "t6_peak");
      apb_write(A_PEAK, 32'd0); m_peak = '0;
      rd_chk(A_PEAK, exp_peak(), "t6_peak_clr");

      // Randomised single-shot measurements against the model
      for (int it = 0; it < 10; it++) begin
         rnd_d = (it == 0) ? 32'd0 : $urandom;
         apb_write(A_WINDOW, rnd_d);
         m_window = (rnd_d[15:0] == 16'd0) ? 16'd1 : rnd_d[15:0];
         rnd_d = $urandom;
         apb_write(A_THRESH, rnd_d); m_thresh = rnd_d[16:0];
         rnd_mask = 4'($urandom_range(0, 15));
         apb_write(A_STATUS, {28'd0, rnd_mask}); model_w1c(rnd_mask);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge PCLK); #1;
            est_done = 1'b1; est_snr = 17'($urandom);
            @(posedge PCLK); #1;
            est_done = 1'b0;
            m_ovr = 1'b1;
         end
         rnd_ie = 1'($urandom_range(0, 1));
         m_irq_en = rnd_ie;
         single_measure(int'($urandom_range(1, 90)), 17'($urandom));
         check_val("rnd_irq", {31'd0, irq}, exp_irq());
         rd_chk(A_RESULT, {15'd0, m_result}, "rnd_result");
         rd_chk(A_COUNT, m_count, "rnd_count");
         rd_chk(A_STATUS, exp_status(1'b0), "rnd_status");
         rd_chk(A_PEAK, exp_peak(), "rnd_peak");
      end
      apb_read(A_CTRL, rd_data, rd_err);
      check_val("final_ctrl", rd_data, {29'd0, m_irq_en, 2'b01});

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
